// File: rtl/gf2m_mult_arbiter.sv
// Round-robin sequencer that shares one digit-serial GF(2^233) multiplier between two requesters.
// Optional RUN watchdog enabled by defining GF2M_MULT_TIMEOUT_EN.
module gf2m_mult_arbiter #(
    parameter int M       = 233,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [M-1:0] a0,
    input  logic [M-1:0] b0,
    output logic         done0,
    input  logic         req1,
    input  logic [M-1:0] a1,
    input  logic [M-1:0] b1,
    output logic         done1,
    output logic [M-1:0] result,
    output logic         err,
    output logic         busy,
    output logic         gnt_id,
    output logic         mult_en,
    output logic [M-1:0] mult_a,
    output logic [M-1:0] mult_b,
    input  logic         mult_rdy,
    input  logic [M-1:0] mult_c
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

    state_t state, state_nx;
    logic   rr;
    logic   grant, gid;
    logic   tmo, fin;

    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_tmo_range
        $error("TIMEOUT must fit the 8-bit watchdog counter");
    end

    always_comb begin
        grant = 1'b0;
        gid   = 1'b0;
        if (req0 && req1) begin
            grant = 1'b1;
            gid   = rr;
        end else if (req0) begin
            grant = 1'b1;
        end else if (req1) begin
            grant = 1'b1;
            gid   = 1'b1;
        end
    end

`ifdef GF2M_MULT_TIMEOUT_EN
    logic [7:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (state == IDLE)
            tcnt <= '0;
        else if (state == RUN && !mult_rdy)
            tcnt <= tcnt + 8'd1;
    end

    assign tmo = !mult_rdy && (tcnt == 8'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // rdy always wins over a coincident timeout
    assign fin = (state == RUN) && (mult_rdy || tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = RUN;
            RUN:     if (fin)   state_nx = DONE;
            DONE:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_en <= 1'b0;
            mult_a  <= '0;
            mult_b  <= '0;
            result  <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            gnt_id  <= 1'b0;
            rr      <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    mult_a  <= gid ? a1 : a0;
                    mult_b  <= gid ? b1 : b0;
                    gnt_id  <= gid;
                    rr      <= ~gid;
                    mult_en <= 1'b1;
                    busy    <= 1'b1;
                end
                RUN: if (fin) begin
                    result  <= mult_rdy ? mult_c : '0;
                    err     <= !mult_rdy;
                    done0   <= !gnt_id;
                    done1   <= gnt_id;
                    mult_en <= 1'b0;
                end
                GAP:     busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_mult_arbiter.sv
// Directed bench for gf2m_mult_arbiter with a fixed-latency GF(2^233) multiplier stub.
module tb_gf2m_mult_arbiter;

    localparam int M   = 233;
    localparam int LAT = 4;   // stub raises rdy on the LAT-th edge with en high

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [M-1:0] a0, b0, a1, b1;
    logic         done0, done1, err, busy, gnt_id;
    logic [M-1:0] result;
    logic         mult_en, mult_rdy;
    logic [M-1:0] mult_a, mult_b, mult_c;
    logic         stall;
    int           scnt;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    gf2m_mult_arbiter #(.M(M), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .done0(done0),
        .req1(req1), .a1(a1), .b1(b1), .done1(done1),
        .result(result), .err(err), .busy(busy), .gnt_id(gnt_id),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
        .mult_rdy(mult_rdy), .mult_c(mult_c)
    );

    // Reference field multiply, modulus x^233 + x^74 + 1
    function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r, x;
        logic         c;
        r = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ x;
            c = x[M-1];
            x = x << 1;
            if (c) begin
                x[74] = ~x[74];
                x[0]  = ~x[0];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!mult_en) begin
            scnt     <= 0;
            mult_rdy <= 1'b0;
        end else if (!stall) begin
            if (scnt == LAT - 1) begin
                mult_rdy <= 1'b1;
                mult_c   <= gfmul(mult_a, mult_b);
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    // Waits for any done pulse; reports cycles, en-high/en-low samples and overlaps seen.
    task automatic wait_done(input int limit, output bit got, output int cyc,
                             output int en_hi, output int en_lo, output int ovl);
        got = 0; cyc = 0; en_hi = 0; en_lo = 0; ovl = 0;
        while (!got && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (mult_en) en_hi++;
            else if (en_hi == 0) en_lo++;
            if (done0 && done1) ovl++;
            if (done0 || done1) got = 1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        stall = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        stall = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({mult_en, done0, done1, err, busy, gnt_id} !== 6'b0 ||
            result !== '0 || mult_a !== '0 || mult_b !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b d0=%b d1=%b err=%b busy=%b gnt=%b res=%h a=%h b=%h",
                     mult_en, done0, done1, err, busy, gnt_id, result, mult_a, mult_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || mult_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: busy=%b en=%b want 0 0", busy, mult_en);
        end
    endtask

    task automatic test_single();
        bit got; int cyc, hi, lo, ov;
        a0 = 1; b0 = 1; req0 = 1;
        wait_done(50, got, cyc, hi, lo, ov);
        req0 = 0;
        total++;
        if (!got || done0 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got=%b d0=%b d1=%b want 1 1 0", got, done0, done1);
        end
        total++;
        if (result !== 233'd1 || err !== 1'b0 || gnt_id !== 1'b0) begin
            bad++;
            $display("FAIL single_result: res=%h err=%b gnt=%b want 1 0 0", result, err, gnt_id);
        end
        total++;
        if (cyc != LAT + 2 || hi != LAT + 1) begin
            bad++;
            $display("FAIL single_timing: cyc=%0d en_hi=%0d want %0d %0d", cyc, hi, LAT + 2, LAT + 1);
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b0 || mult_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_pulse: d0=%b en=%b busy=%b want 0 0 1", done0, mult_en, busy);
        end
        @(negedge clk);
        total++;
        if (mult_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_gap: en=%b busy=%b want 0 0", mult_en, busy);
        end
    endtask

    task automatic test_reduction();
        bit got; int cyc, hi, lo, ov;
        logic [M-1:0] exp;
        exp = '0; exp[74] = 1'b1; exp[0] = 1'b1;
        a1 = '0; a1[1] = 1'b1;
        b1 = '0; b1[232] = 1'b1;
        req1 = 1;
        wait_done(50, got, cyc, hi, lo, ov);
        req1 = 0;
        total++;
        if (!got || done1 !== 1'b1 || gnt_id !== 1'b1) begin
            bad++;
            $display("FAIL reduce_done: got=%b d1=%b gnt=%b want 1 1 1", got, done1, gnt_id);
        end
        total++;
        if (result !== exp) begin
            bad++;
            $display("FAIL reduce_result: res=%h want %h", result, exp);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        bit got; int cyc, hi, lo, ov;
        logic [2:0] ids;
        apply_reset();
        a0 = 233'd2; b0 = 233'd3; a1 = 233'd3; b1 = 233'd3;
        for (int round = 0; round < 2; round++) begin
            req0 = 1; req1 = 1;
            for (int k = 0; k < 2; k++) begin
                wait_done(50, got, cyc, hi, lo, ov);
                ids = {got, done1, done0};
                if (done0) req0 = 0;
                if (done1) req1 = 0;
                total++;
                if (ids !== (k == 0 ? 3'b101 : 3'b110) || ov != 0) begin
                    bad++;
                    $display("FAIL contention_order r%0d k%0d: got/d1/d0=%b ovl=%0d want %b",
                             round, k, ids, ov, (k == 0 ? 3'b101 : 3'b110));
                end
                total++;
                if (result !== (k == 0 ? 233'd6 : 233'd5)) begin
                    bad++;
                    $display("FAIL contention_result r%0d k%0d: res=%h want %h",
                             round, k, result, (k == 0 ? 233'd6 : 233'd5));
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int cyc, hi, lo, ov;
        logic [5:0] seq;
        int ovl_tot, gap_bad;
        seq = '0; ovl_tot = 0; gap_bad = 0;
        a0 = 233'd1; b0 = 233'd1; a1 = 233'd1; b1 = 233'd1;
        req0 = 1; req1 = 1;
        for (int k = 0; k < 6; k++) begin
            wait_done(50, got, cyc, hi, lo, ov);
            seq[k] = got ? done1 : 1'bx;
            ovl_tot += ov;
            if (k > 0 && lo < 2) gap_bad++;
        end
        req0 = 0; req1 = 0;
        total++;
        if (seq !== 6'b101010) begin
            bad++;
            $display("FAIL b2b_sequence: ids(k5..k0)=%b want 101010", seq);
        end
        total++;
        if (ovl_tot != 0 || gap_bad != 0) begin
            bad++;
            $display("FAIL b2b_gap: overlaps=%0d short_gaps=%0d want 0 0", ovl_tot, gap_bad);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got; int cyc, hi, lo, ov;
        int spurious;
        a0 = 233'd7; b0 = 233'd9; req0 = 1;
        cyc = 0;
        while (!mult_en && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mult_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: en=%b busy=%b want 0 0", mult_en, busy);
        end
        req0 = 0;
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) spurious++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1 || busy) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL reset_mid_nodone: spurious=%0d want 0", spurious);
        end
        a0 = 233'd3; b0 = 233'd3; req0 = 1;
        wait_done(50, got, cyc, hi, lo, ov);
        req0 = 0;
        total++;
        if (!got || done0 !== 1'b1 || result !== 233'd5) begin
            bad++;
            $display("FAIL reset_mid_after: got=%b d0=%b res=%h want 1 1 5", got, done0, result);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit got; int cyc, hi, lo, ov;
        stall = 1;
        a0 = 233'd5; b0 = 233'd5; req0 = 1;
`ifdef GF2M_MULT_TIMEOUT_EN
        wait_done(40, got, cyc, hi, lo, ov);
        req0 = 0;
        total++;
        if (!got || done0 !== 1'b1 || cyc != 17) begin
            bad++;
            $display("FAIL timeout_done: got=%b d0=%b cyc=%0d want 1 1 17", got, done0, cyc);
        end
        total++;
        if (err !== 1'b1 || result !== '0) begin
            bad++;
            $display("FAIL timeout_err: err=%b res=%h want 1 0", err, result);
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || mult_en !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: busy=%b en=%b want 0 0", busy, mult_en);
        end
`else
        wait_done(100, got, cyc, hi, lo, ov);
        total++;
        if (got || busy !== 1'b1 || mult_en !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_hang: got=%b busy=%b en=%b err=%b want 0 1 1 0",
                     got, busy, mult_en, err);
        end
        req0 = 0;
`endif
        apply_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_reduction();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
